edge_period_meter: RTL and testbench
====================================

# edge_period_meter

Measures the period and high time of a slow external square-wave input pin, counted in cycles of the fabric clock. It is the input-side counterpart of the free-running counter that divides a PLL clock down to drive an LED: that block produces a known toggle rate, and this block recovers a rate from a pin. It sits between an I/O pad and status/debug logic, and publishes one measurement per input period with a valid pulse.

## Interface
Parameters:
- `CNT_W`, default 25: width of the cycle counter and of the measurement outputs.
- `SYNC_STAGES`, default 2, minimum 2: number of flops in the input synchroniser.

Ports:
- `clk`, input, 1 bit: the only clock; all logic on its rising edge.
- `rst`, input, 1 bit: synchronous, active-high reset.
- `sig_in`, input, 1 bit: asynchronous input pin.
- `period`, output, `CNT_W` bits: cycles between the last two rising edges.
- `high_time`, output, `CNT_W` bits: cycles from a rising edge to the following falling edge, for the same period.
- `period_valid`, output, 1 bit: single-cycle pulse; `period` and `high_time` were updated in this cycle.
- `timeout`, output, 1 bit: level; no rising edge was seen for 2^`CNT_W`-1 cycles.

## Operation
- **Synchroniser and edge detect**
  - `sig_in` passes through `SYNC_STAGES` flops to give `s`; `prev` is `s` delayed by one cycle.
  - `rise` = `s & ~prev`; `fall` = `~s & prev`. Both are combinational and internal.
- **Counter `cnt`**, `CNT_W` bits:
  - Set to 1 on a cycle with `rise`.
  - Otherwise increments, saturating at MAX = 2^`CNT_W`-1.
- **State machine**, states IDLE, MEASURE, TIMEOUT:
  - IDLE: `rise` moves to MEASURE and sets `cnt`=1; no output. `fall` is ignored.
  - MEASURE, on `fall`: `hi_pend` <= `cnt`.
  - MEASURE, on `rise`:
    - `period` <= `cnt`, `high_time` <= `hi_pend`, `period_valid` <= 1, `cnt` <= 1.
    - `fall` and `rise` cannot coincide.
  - MEASURE, `cnt`==MAX with no `rise`: move to TIMEOUT; `timeout` <= 1; `cnt` holds at MAX.
  - MEASURE, `rise` in the same cycle as `cnt`==MAX: the rise wins. `period`=MAX is published with `period_valid`, and the state stays MEASURE.
  - TIMEOUT, on `rise`: move to MEASURE, `cnt` <= 1, `timeout` <= 0, no `period_valid`. The stale interval is discarded.
- **Arithmetic:** unsigned `CNT_W`-bit values only; no wrap-around. `period` and `high_time` keep their last published values until the next `period_valid`.
- **Reset:**
  - All outputs go to 0: `period`, `high_time`, `period_valid`, `timeout`.
  - State goes to IDLE; `cnt`, `hi_pend`, the sync flops and `prev` are cleared to 0.
  - A reset in the middle of a measurement aborts it. Two new rising edges are needed before the next `period_valid`.
  - If `sig_in` is already high after reset, the synchroniser produces a `rise`. IDLE treats it as a first edge.

## Timing
- Latency from `sig_in` to `rise`: `rise` is true in the cycle after the `SYNC_STAGES`-th clock edge that samples the new level.
- `period_valid`, `period` and `high_time` are registered. They are visible one cycle after the `rise` cycle, so input edge to valid is `SYNC_STAGES`+1 cycles.
- `period_valid` is high for exactly one cycle per qualifying rising edge.
- `timeout` asserts one cycle after `cnt` reaches MAX. That is 2^`CNT_W`-1 cycles after the last rise, plus one.
- `timeout` deasserts one cycle after the first rise in TIMEOUT.
- Resolution: a wave with P cycles between rises gives `period`=P. A high phase of H cycles gives `high_time`=H, with P ≥ 2 and H ≥ 1.
- Input transitions faster than one per cycle are not supported and may be missed.

## Test plan
1. **Reset:**
   - Stimulus: hold `rst` for 3 cycles with `sig_in` toggling.
   - Required: `period`=0, `high_time`=0, `period_valid`=0, `timeout`=0 throughout; no `period_valid` before two rises after release.
2. **Steady square wave:**
   - Stimulus: 10 cycles high, 10 cycles low.
   - Required: the first `period_valid` comes after the second rise, then one every 20 cycles, each with `period`=20 and `high_time`=10. Valid lags the `sig_in` rise by `SYNC_STAGES`+1 cycles.
3. **Duty change:**
   - Stimulus: switch the wave to 3 high / 17 low mid-stream.
   - Required: the next `period_valid` shows `period`=20 and `high_time`=3.
4. **Minimum period:**
   - Stimulus: toggle `sig_in` every cycle.
   - Required: `period_valid` every 2 cycles with `period`=2 and `high_time`=1.
5. **Timeout:**
   - Stimulus: `CNT_W`=8; hold `sig_in` low after a rise, then resume a 20-cycle wave.
   - Required: `timeout` rises 256 cycles after the rise cycle. The first resumed rise clears it with no valid; the second resumed rise gives `period`=20.
6. **Reset mid-period:**
   - Stimulus: assert `rst` 5 cycles after a rise.
   - Required: outputs are 0 the next cycle, the state is IDLE, and the old measurement is never published.

Source files
------------

// File: rtl/edge_period_meter.sv
// Measures the period and high time of a slow external square wave in fabric clock
// cycles, publishing one measurement per input period with a single-cycle valid pulse.
module edge_period_meter #(
    parameter int CNT_W       = 25,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        TIMEOUT
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       hi_pend_q, hi_pend_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_time_q, high_time_d;
    logic                   period_valid_q, period_valid_d;
    logic                   timeout_q, timeout_d;

    logic s;
    logic rise;
    logic fall;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

    // NOTE: every _d gets a default before the case so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sync_d         = {sync_q[SYNC_STAGES-2:0], sig_in};
        prev_d         = s;
        cnt_d          = rise ? CNT_ONE : ((cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE);
        state_d        = state_q;
        hi_pend_d      = hi_pend_q;
        period_d       = period_q;
        high_time_d    = high_time_q;
        period_valid_d = 1'b0;
        timeout_d      = timeout_q;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (fall) begin
                    hi_pend_d = cnt_q;
                end
                // A rise landing on the saturated count still publishes MAX rather than timing out.
                if (rise) begin
                    period_d       = cnt_q;
                    high_time_d    = hi_pend_q;
                    period_valid_d = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = TIMEOUT;
                    timeout_d = 1'b1;
                end
            end
            TIMEOUT: begin
                if (rise) begin
                    state_d   = MEASURE;
                    timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments so every flop updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            sync_q         <= '0;
            prev_q         <= 1'b0;
            cnt_q          <= '0;
            hi_pend_q      <= '0;
            period_q       <= '0;
            high_time_q    <= '0;
            period_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_d;
            prev_q         <= prev_d;
            cnt_q          <= cnt_d;
            hi_pend_q      <= hi_pend_d;
            period_q       <= period_d;
            high_time_q    <= high_time_d;
            period_valid_q <= period_valid_d;
            timeout_q      <= timeout_d;
        end
    end

    assign period       = period_q;
    assign high_time    = high_time_q;
    assign period_valid = period_valid_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_edge_period_meter.sv
// Bench for edge_period_meter: drives waveforms cycle by cycle and compares every cycle
// against a model built from input edge times (period, high time, latency, timeout).
module tb_edge_period_meter;

    localparam int W   = 8;
    localparam int S   = 2;
    localparam int MAX = (1 << W) - 1;

    typedef struct packed {
        logic         v;
        logic         t;
        logic [W-1:0] p;
        logic [W-1:0] h;
    } obs_t;

    typedef struct {
        int at;
        int per;
        int hi;
    } meas_t;

    logic         clk    = 1'b0;
    logic         rst    = 1'b1;
    logic         sig_in = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         period_valid;
    logic         timeout;

    edge_period_meter #(
        .CNT_W      (W),
        .SYNC_STAGES(S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_in      (sig_in),
        .period      (period),
        .high_time   (high_time),
        .period_valid(period_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: input edge times (in drive cycles) and what they imply.
    logic  lvl;
    int    last_rise;
    int    last_fall;
    int    landed;
    int    land_q[$];
    meas_t meas_q[$];
    int    held_p;
    int    held_h;
    obs_t  exp_o;
    obs_t  got_o;
    logic  wave[$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void model_clear();
        lvl       = 1'b0;
        last_rise = -1;
        last_fall = -1;
        landed    = -1;
        land_q.delete();
        meas_q.delete();
        held_p    = 0;
        held_h    = 0;
    endfunction

    function automatic void push_level(input logic v, input int n);
        for (int i = 0; i < n; i++) wave.push_back(v);
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("valid=%b timeout=%b period=%0d high=%0d", o.v, o.t, o.p, o.h);
    endfunction

    // A rise driven before edge k reaches the outputs after edge k+S+1; a gap longer than
    // MAX cycles means the meter timed out and that interval is never published.
    task automatic tick(input logic v, input logic r);
        meas_t m;
        meas_t nm;
        int    k;
        k      = cyc;
        rst    = r;
        sig_in = v;
        if (!r) begin
            if (v && !lvl) begin
                if (last_rise >= 0 && k - last_rise <= MAX) begin
                    nm.at  = k + S + 1;
                    nm.per = k - last_rise;
                    nm.hi  = last_fall - last_rise;
                    meas_q.push_back(nm);
                end
                land_q.push_back(k + S + 1);
                last_rise = k;
            end else if (!v && lvl) begin
                last_fall = k;
            end
            lvl = v;
        end
        @(posedge clk);
        #1;
        if (r) model_clear();
        while (land_q.size() > 0 && land_q[0] <= cyc) landed = land_q.pop_front();
        exp_o.v = 1'b0;
        if (meas_q.size() > 0 && meas_q[0].at == cyc) begin
            m       = meas_q.pop_front();
            exp_o.v = 1'b1;
            held_p  = m.per;
            held_h  = m.hi;
        end
        exp_o.t = (landed >= 0) && (cyc - landed >= MAX);
        exp_o.p = W'(held_p);
        exp_o.h = W'(held_h);
        got_o   = {period_valid, timeout, period, high_time};
    endtask

    task automatic apply_reset(input int n);
        for (int i = 0; i < n; i++) tick(logic'(i % 2), 1'b1);
    endtask

    task automatic test_reset();
        int nv = 0;
        for (int i = 0; i < 3; i++) begin
            tick(logic'(i % 2), 1'b1);
            n_cmp++;
            if (got_o !== '0) begin
                n_bad++;
                $display("FAIL reset_hold @%0d: got %s, expected all zero", cyc, fmt(got_o));
            end
        end
        wave.delete();
        push_level(1'b0, 2);
        for (int p = 0; p < 2; p++) begin
            push_level(1'b1, 10);
            push_level(1'b0, 10);
        end
        push_level(1'b1, 10);
        push_level(1'b0, 5);
        foreach (wave[i]) begin
            tick(wave[i], 1'b0);
            if (got_o.v) nv++;
            n_cmp++;
            if (got_o !== exp_o) begin
                n_bad++;
                $display("FAIL reset_release @%0d: got %s, expected %s", cyc, fmt(got_o), fmt(exp_o));
            end
        end
        n_cmp++;
        if (nv !== 2) begin
            n_bad++;
            $display("FAIL reset_valid_count: got %0d, expected 2", nv);
        end
        apply_reset(3);
        wave.delete();
        push_level(1'b1, 8);
        push_level(1'b0, 12);
        push_level(1'b1, 5);
        push_level(1'b0, 5);
        foreach (wave[i]) begin
            tick(wave[i], 1'b0);
            n_cmp++;
            if (got_o !== exp_o) begin
                n_bad++;
                $display("FAIL reset_high_release @%0d: got %s, expected %s", cyc, fmt(got_o), fmt(exp_o));
            end
        end
    endtask

    task automatic test_steady();
        int nv = 0;
        apply_reset(3);
        wave.delete();
        push_level(1'b0, 1);
        for (int p = 0; p < 6; p++) begin
            push_level(1'b1, 10);
            push_level(1'b0, 10);
        end
        foreach (wave[i]) begin
            tick(wave[i], 1'b0);
            if (got_o.v) nv++;
            n_cmp++;
            if (got_o !== exp_o) begin
                n_bad++;
                $display("FAIL steady @%0d: got %s, expected %s", cyc, fmt(got_o), fmt(exp_o));
            end
        end
        n_cmp++;
        if (nv !== 5) begin
            n_bad++;
            $display("FAIL steady_valid_count: got %0d, expected 5", nv);
        end
    endtask

    task automatic test_duty_change();
        int last_h = -1;
        apply_reset(3);
        wave.delete();
        push_level(1'b0, 1);
        for (int p = 0; p < 3; p++) begin
            push_level(1'b1, 10);
            push_level(1'b0, 10);
        end
        for (int p = 0; p < 4; p++) begin
            push_level(1'b1, 3);
            push_level(1'b0, 17);
        end
        foreach (wave[i]) begin
            tick(wave[i], 1'b0);
            if (got_o.v) last_h = int'(high_time);
            n_cmp++;
            if (got_o !== exp_o) begin
                n_bad++;
                $display("FAIL duty @%0d: got %s, expected %s", cyc, fmt(got_o), fmt(exp_o));
            end
        end
        n_cmp++;
        if (last_h !== 3) begin
            n_bad++;
            $display("FAIL duty_last_high: got %0d, expected 3", last_h);
        end
    endtask

    task automatic test_min_period();
        int nv = 0;
        apply_reset(3);
        wave.delete();
        push_level(1'b0, 1);
        for (int p = 0; p < 10; p++) begin
            push_level(1'b1, 1);
            push_level(1'b0, 1);
        end
        push_level(1'b0, 4);
        foreach (wave[i]) begin
            tick(wave[i], 1'b0);
            if (got_o.v) nv++;
            n_cmp++;
            if (got_o !== exp_o) begin
                n_bad++;
                $display("FAIL min_period @%0d: got %s, expected %s", cyc, fmt(got_o), fmt(exp_o));
            end
        end
        n_cmp++;
        if (nv !== 9) begin
            n_bad++;
            $display("FAIL min_period_valid_count: got %0d, expected 9", nv);
        end
    endtask

    task automatic test_timeout();
        int nt = 0;
        apply_reset(3);
        wave.delete();
        push_level(1'b0, 1);
        push_level(1'b1, 5);
        push_level(1'b0, 295);
        for (int p = 0; p < 3; p++) begin
            push_level(1'b1, 10);
            push_level(1'b0, 10);
        end
        // Gap of exactly MAX publishes MAX; a gap of MAX+1 times out for one cycle.
        push_level(1'b1, 5);
        push_level(1'b0, MAX - 5);
        push_level(1'b1, 5);
        push_level(1'b0, MAX + 1 - 5);
        push_level(1'b1, 10);
        push_level(1'b0, 10);
        push_level(1'b1, 5);
        push_level(1'b0, 5);
        foreach (wave[i]) begin
            tick(wave[i], 1'b0);
            if (got_o.t) nt++;
            n_cmp++;
            if (got_o !== exp_o) begin
                n_bad++;
                $display("FAIL timeout @%0d: got %s, expected %s", cyc, fmt(got_o), fmt(exp_o));
            end
        end
        n_cmp++;
        if (nt !== (300 - MAX) + 1) begin
            n_bad++;
            $display("FAIL timeout_cycles: got %0d, expected %0d", nt, (300 - MAX) + 1);
        end
    endtask

    task automatic test_reset_mid();
        int nv = 0;
        apply_reset(3);
        wave.delete();
        push_level(1'b0, 2);
        push_level(1'b1, 10);
        push_level(1'b0, 10);
        push_level(1'b1, 5);
        foreach (wave[i]) begin
            tick(wave[i], 1'b0);
            n_cmp++;
            if (got_o !== exp_o) begin
                n_bad++;
                $display("FAIL reset_mid_pre @%0d: got %s, expected %s", cyc, fmt(got_o), fmt(exp_o));
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b1);
            n_cmp++;
            if (got_o !== '0) begin
                n_bad++;
                $display("FAIL reset_mid_zero @%0d: got %s, expected all zero", cyc, fmt(got_o));
            end
        end
        wave.delete();
        push_level(1'b0, 3);
        for (int p = 0; p < 3; p++) begin
            push_level(1'b1, 10);
            push_level(1'b0, 10);
        end
        foreach (wave[i]) begin
            tick(wave[i], 1'b0);
            if (got_o.v) nv++;
            n_cmp++;
            if (got_o !== exp_o) begin
                n_bad++;
                $display("FAIL reset_mid_post @%0d: got %s, expected %s", cyc, fmt(got_o), fmt(exp_o));
            end
        end
        n_cmp++;
        if (nv !== 2) begin
            n_bad++;
            $display("FAIL reset_mid_valid_count: got %0d, expected 2", nv);
        end
    endtask

    task automatic test_random();
        int h;
        int l;
        apply_reset(3);
        wave.delete();
        push_level(1'b0, 1);
        for (int p = 0; p < 40; p++) begin
            h = int'($urandom_range(40, 1));
            l = ($urandom_range(7, 0) == 0) ? int'($urandom_range(300, 200)) : int'($urandom_range(40, 1));
            push_level(1'b1, h);
            push_level(1'b0, l);
        end
        push_level(1'b1, 4);
        push_level(1'b0, 4);
        foreach (wave[i]) begin
            tick(wave[i], 1'b0);
            n_cmp++;
            if (got_o !== exp_o) begin
                n_bad++;
                $display("FAIL random @%0d: got %s, expected %s", cyc, fmt(got_o), fmt(exp_o));
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_steady();
        test_duty_change();
        test_min_period();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
